// File: rtl/fetch_queue_ctrl.sv
// Fetch-side queue controller: shadows the fetch PC, tags arriving instructions, queues them toward decode.
// Latency: a kept arrival is written at the edge that ends its arrival cycle and is visible at the head one cycle later. The head is read combinationally.
// Backpressure: fetch cannot stall. An arrival that meets a full queue with no pop is dropped and fetch is replayed from that PC.
//
// Ports: clk/rst (sync, active-high); ex_redirect/ex_target (flush + redirect); fetch_inst (1-cycle fetch
// output); pc_src/pc_alu (fetch steering); out_valid/out_ready/out_inst/out_pc (decode side); count (occupancy).
// Optional: define FETCH_QUEUE_PERF_EN to add replay_cnt/squash_cnt saturating event counters.
module fetch_queue_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_redirect,
    input  logic [31:0]            ex_target,
    input  logic [31:0]            fetch_inst,
    output logic                   pc_src,
    output logic [31:0]            pc_alu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]            replay_cnt,
    output logic [15:0]            squash_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   cur_pc_q, cur_pc_d;
    logic [31:0]   slot_pc_q, slot_pc_d;
    logic          slot_valid_q, slot_valid_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   inst_mem_d [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];

    logic pop, push, replay, full;

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign count     = count_q;
    assign pop       = out_valid & out_ready;
    assign full      = (count_q == FULL);

    always_comb begin
        pc_src     = 1'b0;
        pc_alu     = cur_pc_q + 32'd1;
        push       = 1'b0;
        replay     = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;

        if (rst) begin
            pc_src = 1'b1;
            pc_alu = RESET_PC;
        end else if (ex_redirect) begin
            // Flush wins over any pop/push; the arriving slot is wrong-path.
            pc_src   = 1'b1;
            pc_alu   = ex_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // A pop in the same cycle frees the slot, so a full queue can still accept.
            push   = slot_valid_q & (~full | pop);
            replay = slot_valid_q & full & ~pop;
            if (replay) begin
                pc_src = 1'b1;
                pc_alu = slot_pc_q;
            end
            if (push) begin
                inst_mem_d[wr_ptr_q] = fetch_inst;
                pc_mem_d[wr_ptr_q]   = slot_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end

        // pc_alu already equals cur_pc+1 whenever pc_src is low, so it is the next fetch PC.
        cur_pc_d     = pc_alu;
        slot_pc_d    = cur_pc_q;
        slot_valid_d = ~pc_src & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_pc_q     <= RESET_PC;
            slot_pc_q    <= '0;
            slot_valid_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            cur_pc_q     <= cur_pc_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inst_mem_q   <= inst_mem_d;
            pc_mem_q     <= pc_mem_d;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] replay_cnt_q, replay_cnt_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        replay_cnt_d = replay_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (replay && replay_cnt_q != 16'hFFFF) begin
            replay_cnt_d = replay_cnt_q + 16'd1;
        end
        if (ex_redirect && !rst && squash_cnt_q != 16'hFFFF) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            replay_cnt_q <= '0;
            squash_cnt_q <= '0;
        end else begin
            replay_cnt_q <= replay_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign replay_cnt = replay_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Testbench for fetch_queue_ctrl: fetch stage model, vector table, corner sequences, randomized run.
// Latency: not applicable.
// Backpressure: out_ready is driven by the bench, both in fixed patterns and at random.
module tb_fetch_queue_ctrl;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [31:0] fetch_inst;
    logic        pc_src;
    logic [31:0] pc_alu;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] replay_cnt;
    logic [15:0] squash_cnt;
`endif

    fetch_queue_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .fetch_inst  (fetch_inst),
        .pc_src      (pc_src),
        .pc_alu      (pc_alu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .replay_cnt  (replay_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h100 + a;
    endfunction

    // Fetch stage: PC register plus a registered instruction memory read.
    logic [31:0] f_pc      = 32'h0BAD_0000;
    logic [31:0] f_slot_pc = 32'h0BAD_0001;
    logic [31:0] f_inst    = 32'hBAD0_BAD0;
    always @(posedge clk) begin
        f_pc      <= pc_src ? pc_alu : f_pc + 32'd1;
        f_slot_pc <= f_pc;
        f_inst    <= imem(f_pc);
    end
    assign fetch_inst = f_inst;

    // Reference model: the decode-side queue as a plain list of {inst, pc}.
    logic [63:0] mq[$];
    logic        m_prev_src;
    logic [31:0] m_next_pc;
    logic [15:0] m_rep, m_sq;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs to the model, take the edge, advance the model.
    task automatic step();
        logic        e_src, keep, pop, full, push, repl;
        logic [31:0] e_alu;
        logic [63:0] arrival;
        int          sz;
        #2;
        sz      = mq.size();
        keep    = !m_prev_src;
        pop     = (sz != 0) && out_ready;
        full    = (sz == DEPTH);
        repl    = 1'b0;
        push    = 1'b0;
        arrival = {f_inst, f_slot_pc};
        e_src   = 1'b0;
        e_alu   = f_pc + 32'd1;
        if (rst) begin
            e_src = 1'b1;
            e_alu = RESET_PC;
        end else if (ex_redirect) begin
            e_src = 1'b1;
            e_alu = ex_target;
        end else begin
            repl = keep && full && !pop;
            push = keep && (!full || pop);
            if (repl) begin
                e_src = 1'b1;
                e_alu = f_slot_pc;
            end
        end
        chk("pc_src", {31'd0, pc_src}, {31'd0, e_src});
        chk("pc_alu", pc_alu, e_alu);
        chk("count", {29'd0, count}, sz);
        chk("out_valid", {31'd0, out_valid}, {31'd0, (sz != 0)});
        if (sz != 0) begin
            chk("head_pc", out_pc, mq[0][31:0]);
            chk("head_inst", out_inst, mq[0][63:32]);
        end
        if (!rst && !ex_redirect && pop) begin
            chk("order_pc", out_pc, m_next_pc);
            chk("order_inst", out_inst, imem(m_next_pc));
        end
`ifdef FETCH_QUEUE_PERF_EN
        chk("replay_cnt", {16'd0, replay_cnt}, {16'd0, m_rep});
        chk("squash_cnt", {16'd0, squash_cnt}, {16'd0, m_sq});
`endif
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_next_pc = RESET_PC;
            m_rep     = '0;
            m_sq      = '0;
        end else if (ex_redirect) begin
            mq.delete();
            m_next_pc = ex_target;
            if (m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_next_pc = m_next_pc + 32'd1;
            end
            if (push) mq.push_back(arrival);
            if (repl && m_rep != 16'hFFFF) m_rep = m_rep + 16'd1;
        end
        m_prev_src = e_src;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_src;
        logic [31:0] e_alu;
        logic        e_vld;
        int          e_cnt;
        logic [31:0] e_hpc;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // rst, redir, tgt, rdy | src, alu, vld, cnt, head pc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1'b0, 0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1'b0, 0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1'b0, 0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h1,  1'b0, 0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h2,  1'b0, 0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h3,  1'b1, 1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h4,  1'b1, 2, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h5,  1'b1, 3, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  1'b1, 4, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h5,  1'b1, 4, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  1'b1, 4, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h5,  1'b1, 4, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h6,  1'b1, 3, 32'h1};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h5,  1'b1, 4, 32'h1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h6,  1'b1, 4, 32'h1};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h7,  1'b1, 4, 32'h1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h6,  1'b1, 4, 32'h2};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h7,  1'b1, 4, 32'h2};
        tbl[18] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 4, 32'h2};
        tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h41, 1'b0, 0, 32'h0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h42, 1'b0, 0, 32'h0};
        tbl[21] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h43, 1'b1, 1, 32'h40};
    end

    initial begin
        int  n;
        logic found;
        rst         = 1'b1;
        ex_redirect = 1'b0;
        ex_target   = '0;
        out_ready   = 1'b0;
        m_prev_src  = 1'b1;
        m_next_pc   = RESET_PC;
        m_rep       = '0;
        m_sq        = '0;
        @(posedge clk);
        #1;

        // Reset, fill to full with replays, pop-and-push at full, redirect over a replay.
        for (int i = 0; i < 22; i++) begin
            rst         = tbl[i].rst;
            ex_redirect = tbl[i].redir;
            ex_target   = tbl[i].tgt;
            out_ready   = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_src", i), {31'd0, pc_src}, {31'd0, tbl[i].e_src});
            chk($sformatf("tbl%0d_alu", i), pc_alu, tbl[i].e_alu);
            chk($sformatf("tbl%0d_vld", i), {31'd0, out_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_cnt", i), {29'd0, count}, tbl[i].e_cnt);
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_hpc", i), out_pc, tbl[i].e_hpc);
            step();
        end
        ex_redirect = 1'b0;

        // First push lands on the 2nd edge after reset falls.
        rst = 1'b1;
        repeat (3) step();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t1_a_vld", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_b_vld", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_c_vld", {31'd0, out_valid}, 32'd1);
        chk("t1_c_pc", out_pc, 32'h0);
        chk("t1_c_inst", out_inst, 32'h100);
        repeat (8) step();

        // Redirect while pc 5 arrives.
        rst = 1'b1;
        repeat (2) step();
        rst   = 1'b0;
        found = 1'b0;
        for (n = 0; n < 30 && !found; n++) begin
            if (!m_prev_src && f_slot_pc == 32'd5) found = 1'b1;
            else step();
        end
        chk("t2_reach_pc5", {31'd0, found}, 32'd1);
        ex_redirect = 1'b1;
        ex_target   = 32'h40;
        step();
        ex_redirect = 1'b0;
        chk("t2_flush_cnt", {29'd0, count}, 32'd0);
        found = 1'b0;
        for (n = 0; n < 10 && !found; n++) begin
            #1;
            if (out_valid) found = 1'b1;
            else step();
        end
        chk("t2_target_seen", {31'd0, found}, 32'd1);
        chk("t2_target_pc", out_pc, 32'h40);
        chk("t2_target_inst", out_inst, 32'h140);
        repeat (4) step();

        // Reset in mid-stream with three entries queued.
        out_ready = 1'b0;
        found     = 1'b0;
        for (n = 0; n < 20 && !found; n++) begin
            #1;
            if (count == 3'd3) found = 1'b1;
            else step();
        end
        chk("t6_reach_cnt3", {31'd0, found}, 32'd1);
        rst = 1'b1;
        step();
        chk("t6_cnt", {29'd0, count}, 32'd0);
        chk("t6_vld", {31'd0, out_valid}, 32'd0);
        chk("t6_src", {31'd0, pc_src}, 32'd1);
        chk("t6_alu", pc_alu, RESET_PC);
        chk("t6_out_pc", out_pc, 32'd0);
        chk("t6_out_inst", out_inst, 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t6_replay_cnt", {16'd0, replay_cnt}, 32'd0);
        chk("t6_squash_cnt", {16'd0, squash_cnt}, 32'd0);
`endif
        step();
        rst = 1'b0;

        // Randomized run, alternating between draining and filling phases.
        for (int c = 0; c < 4000; c++) begin
            out_ready   = ($urandom_range(0, 99) < (((c / 200) % 2) ? 90 : 20));
            ex_redirect = ($urandom_range(0, 99) < 3);
            ex_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
            rst         = ($urandom_range(0, 999) < 4);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
